// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths and writeback arbiter selection codes
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ADDR_W = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_MEM  = 2'd1,
    SEL_FIFO = 2'd2,
    SEL_ALU  = 2'd3
  } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous fall-through FIFO buffering deferred ALU results
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer MSB separates full (wrapped once) from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register file write arbiter, ALU result buffer and busy scoreboard
module regfile_writeback #(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int ADDR_W     = riscv_pkg::ADDR_W,
  parameter int FIFO_DEPTH = riscv_pkg::FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic [ADDR_W-1:0] chk_rs1,
  input  logic              chk_rs1_en,
  input  logic [ADDR_W-1:0] chk_rs2,
  input  logic              chk_rs2_en,
  input  logic [ADDR_W-1:0] chk_rd,
  input  logic              chk_rd_en,
  output logic              hazard,
  output logic              rg_wrt_en,
  output logic [ADDR_W-1:0] rg_wrt_addr,
  output logic [XLEN-1:0]   rg_wrt_data,
  output logic              wb_idle
);
  import riscv_pkg::*;

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] RZ = ADDR_W'(REG_ZERO);

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic [ADDR_W+XLEN-1:0] fifo_head;
  logic                   alu_fire;
  wb_sel_e                sel;
  logic [ADDR_W-1:0]      sel_rd;
  logic [XLEN-1:0]        sel_data;
  logic [NREG-1:0]        busy;
  logic [NREG-1:0]        busy_nxt;

  // Ready comes from registered occupancy only; a same-cycle pop does not raise it.
  assign alu_ready = !reset && !fifo_full;
  assign alu_fire  = alu_valid && alu_ready;

  always_comb begin
    sel      = SEL_NONE;
    sel_rd   = mem_rd;
    sel_data = mem_data;
    if (reset) begin
      sel = SEL_NONE;
    end else if (mem_valid) begin
      sel = SEL_MEM;
    end else if (!fifo_empty) begin
      sel                = SEL_FIFO;
      {sel_rd, sel_data} = fifo_head;
    end else if (alu_fire) begin
      sel      = SEL_ALU;
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end
  end

  assign fifo_pop  = (sel == SEL_FIFO);
  assign fifo_push = alu_fire && (sel != SEL_ALU);

  wb_fifo #(
    .WIDTH(ADDR_W + XLEN),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  ({alu_rd, alu_data}),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rg_wrt_en   <= 1'b0;
      rg_wrt_addr <= '0;
      rg_wrt_data <= '0;
    end else begin
      rg_wrt_en <= (sel != SEL_NONE) && (sel_rd != RZ);
      if (sel != SEL_NONE) begin
        rg_wrt_addr <= sel_rd;
        rg_wrt_data <= sel_data;
      end
    end
  end

  // Clear lands on the RegFile store edge; a coincident issue to the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (rg_wrt_en) begin
      busy_nxt[rg_wrt_addr] = 1'b0;
    end
    if (iss_valid && (iss_rd != RZ)) begin
      busy_nxt[iss_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign hazard = !reset && ((busy[chk_rs1] && chk_rs1_en) ||
                             (busy[chk_rs2] && chk_rs2_en) ||
                             (busy[chk_rd]  && chk_rd_en));

  assign wb_idle = reset || (fifo_empty && !rg_wrt_en && (busy == '0));

  a_no_waw_issue: assert property (@(posedge clk) disable iff (reset)
    (iss_valid && (iss_rd != RZ) && busy[iss_rd]) |-> (rg_wrt_en && (rg_wrt_addr == iss_rd)));

endmodule
